// File: rtl/proc_mem_arbiter_if.sv
// Request/response bundle shared by the imem/dmem requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface proc_mem_arbiter_if;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;

  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;

  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_data;

  modport slave (
    input  imemreq_val, imemreq_addr,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  memreq_rdy, memresp_val, memresp_data,
    output imemreq_rdy, imemresp_val, imemresp_data,
    output dmemreq_rdy, dmemresp_val, dmemresp_data,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata
  );

  modport master (
    output imemreq_val, imemreq_addr,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output memreq_rdy, memresp_val, memresp_data,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    input  dmemreq_rdy, dmemresp_val, dmemresp_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata
  );
endinterface

// File: rtl/proc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between imem and dmem, with an in-order tag FIFO
// routing responses. Define PROC_MEM_ARBITER_PERF_CNT_EN to add grant/conflict counters.
module proc_mem_arbiter #(
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic                clk,
  input  logic                rst,
  proc_mem_arbiter_if.slave   bus,
  output logic                resp_err
`ifdef PROC_MEM_ARBITER_PERF_CNT_EN
  ,
  output logic [31:0]         perf_imem_grants,
  output logic [31:0]         perf_dmem_grants,
  output logic [31:0]         perf_conflicts
`endif
);

  localparam int unsigned PtrW = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {PrioImem = 1'b0, PrioDmem = 1'b1} prio_e;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  prio_e           prio_q, prio_d;
  logic            resp_err_q, resp_err_d;
  logic            tags_q [p_max_outstanding];

  logic full, empty, both_val;
  logic gnt_i, gnt_d;
  logic fire, pop, head_tag;

  assign full     = (count_q == CntW'(p_max_outstanding));
  assign empty    = (count_q == '0);
  assign both_val = bus.imemreq_val && bus.dmemreq_val;
  assign head_tag = tags_q[rd_ptr_q];

  // Grants are suppressed during reset so no handshake output toggles while state is cleared.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!rst && !full) begin
      if (both_val) begin
        gnt_d = (prio_q == PrioDmem);
        gnt_i = (prio_q == PrioImem);
      end else begin
        gnt_i = bus.imemreq_val;
        gnt_d = bus.dmemreq_val;
      end
    end
  end

  assign bus.memreq_val   = gnt_i || gnt_d;
  assign bus.memreq_type  = gnt_d ? bus.dmemreq_type  : 1'b0;
  assign bus.memreq_addr  = gnt_d ? bus.dmemreq_addr  : bus.imemreq_addr;
  assign bus.memreq_wdata = gnt_d ? bus.dmemreq_wdata : 32'h0;

  assign bus.imemreq_rdy = gnt_i && bus.memreq_rdy;
  assign bus.dmemreq_rdy = gnt_d && bus.memreq_rdy;

  assign fire = bus.memreq_val && bus.memreq_rdy;
  assign pop  = !rst && bus.memresp_val && !empty;

  assign bus.imemresp_val  = pop && !head_tag;
  assign bus.dmemresp_val  = pop && head_tag;
  assign bus.imemresp_data = bus.memresp_data;
  assign bus.dmemresp_data = bus.memresp_data;

  assign resp_err = resp_err_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    prio_d     = prio_q;
    resp_err_d = resp_err_q;

    if (fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({fire, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Round-robin only advances when there was an actual contest.
    if (fire && both_val) begin
      if (gnt_d) prio_d = PrioImem;
      else       prio_d = PrioDmem;
    end

    if (bus.memresp_val && empty) resp_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prio_q     <= PrioDmem;
      resp_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prio_q     <= prio_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q says they are live.
  always_ff @(posedge clk) begin
    if (fire) tags_q[wr_ptr_q] <= gnt_d;
  end

`ifdef PROC_MEM_ARBITER_PERF_CNT_EN
  logic [31:0] perf_imem_q, perf_dmem_q, perf_conf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_imem_q <= '0;
      perf_dmem_q <= '0;
      perf_conf_q <= '0;
    end else begin
      if (fire && gnt_i)      perf_imem_q <= perf_imem_q + 32'd1;
      if (fire && gnt_d)      perf_dmem_q <= perf_dmem_q + 32'd1;
      if (both_val && !full)  perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_imem_grants = perf_imem_q;
  assign perf_dmem_grants = perf_dmem_q;
  assign perf_conflicts   = perf_conf_q;
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Scoreboard bench for proc_mem_arbiter: drivers push expected responses, a negedge monitor
// pops and compares, and a behavioural in-order memory supplies responses.
module tb_proc_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic resp_err;
  always #5 clk = ~clk;

  proc_mem_arbiter_if bus();

`ifdef PROC_MEM_ARBITER_PERF_CNT_EN
  logic [31:0] perf_i, perf_d, perf_c;
`endif

  proc_mem_arbiter #(.p_max_outstanding(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .resp_err (resp_err)
`ifdef PROC_MEM_ARBITER_PERF_CNT_EN
    ,
    .perf_imem_grants (perf_i),
    .perf_dmem_grants (perf_d),
    .perf_conflicts   (perf_c)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic [31:0] data;} mresp_t;
  mresp_t      pend[$];
  int          lat = 1;
  bit          hold_resp = 1'b0;
  bit          inject = 1'b0;

  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  int          fire_cyc[$];
  bit          fire_tag[$];
  int          iresp_cyc[$];
  int          any_resp_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not as required (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  // Memory model: capture fires at negedge, present responses in order after `lat` cycles.
  initial forever begin
    @(negedge clk);
    if (rst) pend.delete();
    else if (bus.memreq_val && bus.memreq_rdy)
      pend.push_back('{cyc + lat, bus.memreq_type ? ~bus.memreq_wdata
                                                  : rd_data(bus.memreq_addr)});
  end

  initial begin
    bus.memresp_val  = 1'b0;
    bus.memresp_data = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      bus.memresp_val = 1'b0;
      if (rst) begin
        pend.delete();
      end else if (inject) begin
        bus.memresp_val  = 1'b1;
        bus.memresp_data = 32'hBAD0_0000;
      end else if (!hold_resp && pend.size() > 0 && pend[0].due <= cyc) begin
        mresp_t m;
        m = pend.pop_front();
        bus.memresp_val  = 1'b1;
        bus.memresp_data = m.data;
      end
    end
  end

  // Monitor: response scoreboard and per-fire payload checks.
  initial forever begin
    @(negedge clk);
    if (bus.imemresp_val) begin
      if (exp_i.size() == 0) fail("imem_resp_unexpected");
      else check("imem_resp_data", 64'(bus.imemresp_data), 64'(exp_i.pop_front()));
      iresp_cyc.push_back(cyc);
      any_resp_cyc.push_back(cyc);
    end
    if (bus.dmemresp_val) begin
      if (exp_d.size() == 0) fail("dmem_resp_unexpected");
      else check("dmem_resp_data", 64'(bus.dmemresp_data), 64'(exp_d.pop_front()));
      any_resp_cyc.push_back(cyc);
    end
    if (bus.memreq_val && bus.memreq_rdy) begin
      check("rdy_onehot", 64'(bus.imemreq_rdy ^ bus.dmemreq_rdy), 64'd1);
      if (bus.dmemreq_rdy) begin
        check("memreq_addr_d", 64'(bus.memreq_addr), 64'(bus.dmemreq_addr));
        check("memreq_type_d", 64'(bus.memreq_type), 64'(bus.dmemreq_type));
        check("memreq_wdata_d", 64'(bus.memreq_wdata), 64'(bus.dmemreq_wdata));
      end else begin
        check("memreq_addr_i", 64'(bus.memreq_addr), 64'(bus.imemreq_addr));
        check("memreq_type_wdata_i", {31'h0, bus.memreq_type, bus.memreq_wdata}, 64'd0);
      end
      fire_cyc.push_back(cyc);
      fire_tag.push_back(bus.dmemreq_rdy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic imem_req(input logic [31:0] a);
    bit ok = 1'b0;
    exp_i.push_back(rd_data(a));
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = a;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.imemreq_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) fail("imem_req_timeout");
    step();
    bus.imemreq_val = 1'b0;
  endtask

  task automatic dmem_req(input logic t, input logic [31:0] a, input logic [31:0] wd);
    bit ok = 1'b0;
    exp_d.push_back(t ? ~wd : rd_data(a));
    bus.dmemreq_val   = 1'b1;
    bus.dmemreq_type  = t;
    bus.dmemreq_addr  = a;
    bus.dmemreq_wdata = wd;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.dmemreq_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) fail("dmem_req_timeout");
    step();
    bus.dmemreq_val = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_i.size() == 0 && exp_d.size() == 0 && pend.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("wait_idle_timeout");
    step();
  endtask

  task automatic clear_logs();
    fire_cyc.delete();
    fire_tag.delete();
    iresp_cyc.delete();
    any_resp_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_i.delete();
    exp_d.delete();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [5:0] hs_outs();
    return {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy,
            bus.imemresp_val, bus.dmemresp_val, resp_err};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] ord;
    rst               = 1'b1;
    bus.imemreq_val   = 1'b0;
    bus.imemreq_addr  = 32'h0;
    bus.dmemreq_val   = 1'b0;
    bus.dmemreq_type  = 1'b0;
    bus.dmemreq_addr  = 32'h0;
    bus.dmemreq_wdata = 32'h0;
    bus.memreq_rdy    = 1'b1;

    // Reset state
    step();
    @(negedge clk);
    check("reset_outputs_during", 64'(hs_outs()), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs_after", 64'(hs_outs()), 64'd0);
    step();

    // Single imem stream, latency 1
    clear_logs();
    imem_req(32'h00);
    imem_req(32'h04);
    imem_req(32'h08);
    wait_idle();
    check("t1_fires", 64'(fire_cyc.size()), 64'd3);
    check("t1_resps", 64'(iresp_cyc.size()), 64'd3);
    if (fire_cyc.size() == 3 && iresp_cyc.size() == 3) begin
      check("t1_consecutive", 64'(fire_cyc[2] - fire_cyc[0]), 64'd2);
      for (int k = 0; k < 3; k++)
        check("t1_latency", 64'(iresp_cyc[k] - fire_cyc[k]), 64'd1);
    end

    // Conflict: dmem wins first after reset, then alternation
    do_reset();
    clear_logs();
    fork
      begin imem_req(32'h10); imem_req(32'h14); end
      begin dmem_req(1'b1, 32'h100, 32'hDEAD); dmem_req(1'b0, 32'h104, 32'h0); end
    join
    wait_idle();
    check("t2_fires", 64'(fire_tag.size()), 64'd4);
    if (fire_tag.size() == 4)
      check("t2_grant_order", {60'h0, fire_tag[0], fire_tag[1], fire_tag[2], fire_tag[3]},
            64'b1010);

    // Full FIFO: responses withheld
    clear_logs();
    lat = 1;
    hold_resp = 1'b1;
    fork
      for (int k = 0; k < 5; k++) imem_req(32'h20 + 32'(k) * 4);
      begin
        for (int k = 0; k < 50 && fire_cyc.size() < 4; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("t3_stalled", {62'h0, bus.memreq_val, bus.imemreq_rdy}, 64'd0);
        end
        check("t3_fires_at_full", 64'(fire_cyc.size()), 64'd4);
        step();
        hold_resp = 1'b0;
      end
    join
    wait_idle();
    check("t3_fires_total", 64'(fire_cyc.size()), 64'd5);
    if (fire_cyc.size() == 5 && iresp_cyc.size() > 0)
      check("t3_refire_cycle", 64'(fire_cyc[4] - iresp_cyc[0]), 64'd1);

    // Push/pop same cycle at count 2, wrap after 10 interleaved transactions
    do_reset();
    clear_logs();
    lat = 2;
    fork
      for (int k = 0; k < 5; k++) imem_req(32'h40 + 32'(k) * 4);
      for (int k = 0; k < 5; k++) dmem_req(1'b0, 32'h200 + 32'(k) * 4, 32'h0);
    join
    wait_idle();
    check("t4_fires", 64'(fire_cyc.size()), 64'd10);
    check("t4_resps", 64'(any_resp_cyc.size()), 64'd10);
    if (fire_cyc.size() == 10 && any_resp_cyc.size() == 10) begin
      ord = '0;
      for (int k = 0; k < 10; k++) ord = {ord[8:0], fire_tag[k]};
      check("t4_grant_order", 64'(ord), 64'b1010101010);
      check("t4_no_stall", 64'(fire_cyc[9] - fire_cyc[0]), 64'd9);
      check("t4_last_latency", 64'(any_resp_cyc[9] - fire_cyc[9]), 64'd2);
    end
`ifdef PROC_MEM_ARBITER_PERF_CNT_EN
    check("perf_imem", 64'(perf_i), 64'd5);
    check("perf_dmem", 64'(perf_d), 64'd5);
    check("perf_conflicts", 64'(perf_c), 64'd9);
`endif

    // Orphan response
    do_reset();
    lat = 1;
    inject = 1'b1;
    @(negedge clk);
    check("t5_orphan_no_valid", {62'h0, bus.imemresp_val, bus.dmemresp_val}, 64'd0);
    check("t5_err_not_yet", 64'(resp_err), 64'd0);
    step();
    inject = 1'b0;
    @(negedge clk);
    check("t5_err_set", 64'(resp_err), 64'd1);
    repeat (3) step();
    @(negedge clk);
    check("t5_err_sticky", 64'(resp_err), 64'd1);
    step();
    do_reset();
    @(negedge clk);
    check("t5_err_cleared", 64'(resp_err), 64'd0);
    step();

    // Reset mid-flight with 3 outstanding
    hold_resp = 1'b1;
    for (int k = 0; k < 3; k++) imem_req(32'h80 + 32'(k) * 4);
    rst = 1'b1;
    exp_i.delete();
    exp_d.delete();
    hold_resp = 1'b0;
    bus.imemreq_val  = 1'b1;
    bus.imemreq_addr = 32'h300;
    bus.dmemreq_val  = 1'b1;
    bus.dmemreq_type = 1'b0;
    bus.dmemreq_addr = 32'h400;
    @(negedge clk);
    check("t6_outputs_in_reset",
          {59'h0, bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy,
           bus.imemresp_val, bus.dmemresp_val}, 64'd0);
    step();
    rst = 1'b0;
    bus.memreq_rdy = 1'b0;
    @(negedge clk);
    check("t6_prio_dmem", {31'h0, bus.memreq_val, bus.memreq_addr}, {31'h0, 1'b1, 32'h400});
    step();
    bus.imemreq_val = 1'b0;
    bus.dmemreq_val = 1'b0;
    bus.memreq_rdy  = 1'b1;
    inject = 1'b1;
    step();
    inject = 1'b0;
    @(negedge clk);
    check("t6_count_cleared", 64'(resp_err), 64'd1);
    step();
    do_reset();
    @(negedge clk);
    check("t6_final_idle", 64'(hs_outs()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
- Shares one memory port between the processor's instruction-fetch requester (imem) and data requester (dmem).
- Used by the multi-cycle and pipelined processor variants when only a single-ported memory is available.
- Requests use val/rdy handshakes; responses are val-only. Round-robin arbitration on conflict.
- An in-order tag FIFO records which requester owns each outstanding memory transaction, so every response is routed back to the right requester.

Parameters:
- p_max_outstanding, 4: depth of the tag FIFO (maximum in-flight memory transactions); power of 2, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- imemreq_val  input  1  instruction request valid
- imemreq_rdy  output  1  instruction request accepted this cycle
- imemreq_addr  input  32  instruction address
- imemresp_val  output  1  instruction response valid
- imemresp_data  output  32  instruction response data
- dmemreq_val  input  1  data request valid
- dmemreq_rdy  output  1  data request accepted this cycle
- dmemreq_type  input  1  0=read, 1=write
- dmemreq_addr  input  32  data address
- dmemreq_wdata  input  32  write data
- dmemresp_val  output  1  data response valid (reads and write acks)
- dmemresp_data  output  32  data response read data
- memreq_val  output  1  memory request valid
- memreq_rdy  input  1  memory can accept request
- memreq_type  output  1  0=read, 1=write
- memreq_addr  output  32  memory address
- memreq_wdata  output  32  memory write data
- memresp_val  input  1  memory response valid; responses arrive in request order
- memresp_data  input  32  memory response data
- resp_err  output  1  sticky flag: a response arrived with no outstanding transaction

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: tag FIFO empty (count=0, pointers=0), prio=DMEM, resp_err=0.
- Reset outputs: with inputs idle, every valid/ready output is 0 during and after reset.
- Full flag: full = (count == p_max_outstanding), based on the registered count only. A pop in the same cycle does not free a slot.
- Grant logic (combinational): evaluated only when !full.
  - Only one requester valid: grant that requester.
  - Both valid: grant the requester selected by prio.
- Request mux: memreq_val = grant_any.
  - memreq_type/addr/wdata come from the granted requester.
  - For an imem grant, type=0 and wdata=0.
- Requester ready: {i,d}memreq_rdy = granted && memreq_rdy. The non-granted requester sees rdy=0.
- Accept (fire) = memreq_val && memreq_rdy.
  - On fire: push tag (0=imem, 1=dmem).
  - If both requesters were valid, prio toggles to the other requester.
  - With a single requester valid, prio is unchanged.
- Response routing: when memresp_val && count>0, pop the head tag.
  - imemresp_val = memresp_val && count>0 && head==0.
  - dmemresp_val = the same with head==1.
  - Both response data outputs = memresp_data, combinational and same cycle (zero added latency).
- Request-to-response latency equals the memory latency; the arbiter adds no cycles on either path.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap-around: pointers wrap modulo p_max_outstanding.
- Orphan response (memresp_val && count==0):
  - Both response valids stay 0.
  - resp_err is set to 1 and stays set until rst.
- Reset mid-operation: outstanding tags are discarded. The memory must be reset together with the arbiter; any late response is handled as an orphan.
- Requester obligations: requesters hold val and payload stable until rdy. The arbiter does not register the request payload.

Optional Feature:
- Macro: PROC_MEM_ARBITER_PERF_CNT_EN.
- When defined, three added 32-bit outputs, each reset to 0 and wrapping modulo 2^32:
  - perf_imem_grants: increments on each imem fire.
  - perf_dmem_grants: increments on each dmem fire.
  - perf_conflicts: increments in every cycle where both requests are valid and !full.
- When not defined, these ports and their counters are absent. All other behaviour is identical.

Test Plan:
- Single imem stream: imem reads to 0x00,0x04,0x08; memory latency 1 with data 0xA0,0xA1,0xA2 -> memreq issued on consecutive cycles; imemresp_val for 3 cycles with 0xA0,0xA1,0xA2; dmemresp_val always 0.
- Conflict: both requesters valid for 4 cycles after reset (dmem write 0x100←0xDEAD) -> grant order dmem,imem,dmem,imem; each response routed to the requester that issued it.
- Full FIFO: memreq_rdy=1, responses withheld, imem valid continuously -> exactly 4 fires; then imemreq_rdy=0 and memreq_val=0 until the first memresp_val, with a new fire one cycle later.
- Push and pop in the same cycle at count=2 -> count remains 2; pointers wrap correctly after 10 transactions; all tags stay in order.
- Orphan response: memresp_val=1 with count=0 -> resp_err goes 1 the next cycle and stays 1; both response valids are 0; rst clears resp_err.
- Reset mid-flight: 3 outstanding transactions, rst asserted for 1 cycle -> count=0, prio=DMEM, all valid/ready outputs 0 during reset.
